add_header_buffered: RTL

Store-and-forward packet header inserter for the AXI-Stream data path. It buffers each input packet completely and measures its byte length on the input side. It then emits a 1-beat header (length, sequence number, user tag) followed by the packet. It generalises the single-header inserter with parametrised depths, a structured header, a runtime bypass mode, and deadlock detection.

---
 rtl/add_header_buffered.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/add_header_buffered.sv
// Store-and-forward AXI-Stream header inserter: buffers whole packets, counts their bytes on
// ingress, then emits an optional one-beat header {user_tag, seq, length} ahead of each packet.
module add_header_buffered #(
    parameter int DW         = 128,
    parameter int DATA_DEPTH = 2048,
    parameter int PLEN_DEPTH = 16,
    parameter int LW         = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW-1:0]   axis_in_tdata,
    input  logic [DW/8-1:0] axis_in_tkeep,
    input  logic            axis_in_tlast,
    input  logic            axis_in_tvalid,
    output logic            axis_in_tready,
    output logic [DW-1:0]   axis_out_tdata,
    output logic [DW/8-1:0] axis_out_tkeep,
    output logic            axis_out_tlast,
    output logic            axis_out_tvalid,
    input  logic            axis_out_tready,
    input  logic            header_en,
    input  logic [15:0]     user_tag,
    output logic [LW-1:0]   pkt_count,
    output logic            stall_err
);

    localparam int KW = DW / 8;
    localparam int EW = DW + KW + 1;
    localparam int DA = $clog2(DATA_DEPTH);
    localparam int PA = $clog2(PLEN_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

    function automatic logic [LW-1:0] f_popcount(input logic [KW-1:0] keep);
        logic [LW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KW; i++) begin
            cnt = cnt + {{(LW-1){1'b0}}, keep[i]};
        end
        return cnt;
    endfunction

    // Storage arrays carry no reset; only pointers and control state do.
    logic [EW-1:0]   r_dmem [DATA_DEPTH];
    logic [LW-1:0]   r_pmem [PLEN_DEPTH];
    logic [DA:0]     r_dwp, r_drp;
    logic [PA:0]     r_pwp, r_prp;
    logic [LW-1:0]   r_acc;
    logic [LW-1:0]   r_seq;
    logic [LW-1:0]   r_pkt_cnt;
    logic            r_stall;
    logic            r_in_en;
    logic            r_hdr;
    state_t          r_state;

    logic [DW-1:0]   r_odata;
    logic [KW-1:0]   r_okeep;
    logic            r_olast;
    logic            r_ovalid;

    logic            w_dempty, w_dfull, w_pempty, w_pfull;
    logic            w_in_rdy, w_in_fire;
    logic [LW-1:0]   w_bytes, w_len;
    logic [EW-1:0]   w_dhead;
    logic [LW-1:0]   w_phead;
    logic [DW-1:0]   w_hdr;
    logic            w_load;
    logic            w_out_fire;
    state_t          w_nstate;
    logic            w_take, w_ld_hdr, w_ld_pay, w_pop_last;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_dempty = (r_dwp == r_drp);
    assign w_dfull  = (r_dwp[DA] != r_drp[DA]) && (r_dwp[DA-1:0] == r_drp[DA-1:0]);
    assign w_pempty = (r_pwp == r_prp);
    assign w_pfull  = (r_pwp[PA] != r_prp[PA]) && (r_pwp[PA-1:0] == r_prp[PA-1:0]);

    assign w_in_rdy  = r_in_en && !w_dfull && !w_pfull && !r_stall;
    assign w_in_fire = axis_in_tvalid && w_in_rdy;
    assign w_bytes   = f_popcount(axis_in_tkeep);
    assign w_len     = r_acc + w_bytes;

    assign w_dhead    = r_dmem[r_drp[DA-1:0]];
    assign w_phead    = r_pmem[r_prp[PA-1:0]];
    assign w_load     = !r_ovalid || axis_out_tready;
    assign w_out_fire = r_ovalid && axis_out_tready;

    always_comb begin
        w_hdr = '0;
        w_hdr[LW-1:0]        = w_phead;
        w_hdr[2*LW-1:LW]     = r_seq;
        w_hdr[2*LW+15:2*LW]  = user_tag;
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_dmem[r_dwp[DA-1:0]] <= {axis_in_tlast, axis_in_tkeep, axis_in_tdata};
        end
        if (w_in_fire && axis_in_tlast) begin
            r_pmem[r_pwp[PA-1:0]] <= w_len;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate   = r_state;
        w_take     = 1'b0;
        w_ld_hdr   = 1'b0;
        w_ld_pay   = 1'b0;
        w_pop_last = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_pempty) begin
                    w_take   = 1'b1;
                    w_nstate = header_en ? S_HEADER : S_PAYLOAD;
                end
            end
            S_HEADER: begin
                if (w_load) begin
                    w_ld_hdr = 1'b1;
                    w_nstate = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_load && !w_dempty) begin
                    w_ld_pay = 1'b1;
                    if (w_dhead[EW-1]) begin
                        w_pop_last = 1'b1;
                        w_nstate   = S_IDLE;
                    end
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dwp     <= '0;
            r_drp     <= '0;
            r_pwp     <= '0;
            r_prp     <= '0;
            r_acc     <= '0;
            r_seq     <= '0;
            r_pkt_cnt <= '0;
            r_stall   <= 1'b0;
            r_in_en   <= 1'b0;
            r_hdr     <= 1'b0;
        end else begin
            r_in_en <= 1'b1;
            if (w_in_fire) begin
                r_dwp <= r_dwp + 1'b1;
                if (axis_in_tlast) begin
                    r_pwp <= r_pwp + 1'b1;
                    r_acc <= '0;
                end else begin
                    r_acc <= w_len;
                end
            end
            if (w_ld_pay) begin
                r_drp <= r_drp + 1'b1;
            end
            if (w_pop_last) begin
                r_prp <= r_prp + 1'b1;
                if (r_hdr) begin
                    r_seq <= r_seq + 1'b1;
                end
            end
            if (w_take) begin
                r_hdr <= header_en;
            end
            // A packet that cannot fit can never complete, so nothing will ever drain.
            if (w_dfull && w_pempty) begin
                r_stall <= 1'b1;
            end
            if (w_out_fire && r_olast) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_odata  <= '0;
            r_okeep  <= '0;
            r_olast  <= 1'b0;
            r_ovalid <= 1'b0;
        end else if (w_ld_hdr) begin
            r_odata  <= w_hdr;
            r_okeep  <= '1;
            r_olast  <= 1'b0;
            r_ovalid <= 1'b1;
        end else if (w_ld_pay) begin
            r_odata  <= w_dhead[DW-1:0];
            r_okeep  <= w_dhead[DW+KW-1:DW];
            r_olast  <= w_dhead[EW-1];
            r_ovalid <= 1'b1;
        end else if (axis_out_tready) begin
            r_ovalid <= 1'b0;
        end
    end

    assign axis_in_tready  = w_in_rdy;
    assign axis_out_tdata  = r_odata;
    assign axis_out_tkeep  = r_okeep;
    assign axis_out_tlast  = r_olast;
    assign axis_out_tvalid = r_ovalid;
    assign pkt_count       = r_pkt_cnt;
    assign stall_err       = r_stall;

endmodule
